tristate_bus_arbiter: RTL and testbench
=======================================

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bus data width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4: number of requesting drivers, range 2..16.
REQ-003 The block SHALL have parameter TURNAROUND, default 1: idle cycles between drivers, range 1..15.
REQ-004 The block SHALL have parameter MAX_BURST, default 8: maximum owner tenure in cycles; used only with the timeout feature.
REQ-005 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port req  input  CHANNELS  per-channel bus request, level-sensitive.
REQ-008 The block SHALL have port data_in  input  CHANNELS x WIDTH  per-channel data to drive.
REQ-009 The block SHALL have port bus  inout/tri  WIDTH  shared bus, driven or high-Z.
REQ-010 The block SHALL have port gnt  output  CHANNELS  one-hot grant, all-zero when no owner.
REQ-011 The block SHALL have port owner  output  clog2(CHANNELS)  index of current owner, valid when bus_valid=1.
REQ-012 The block SHALL have port bus_valid  output  1  high exactly when bus is driven.
REQ-013 The block SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and TURN.
REQ-015 In IDLE, and in the last TURN cycle, the first edge sampling any req high SHALL enter DRIVE with the round-robin winner.
REQ-016 Round-robin search SHALL start at last_owner+1 mod CHANNELS; after reset last_owner=CHANNELS-1, so channel 0 has highest priority.
REQ-017 In DRIVE, gnt SHALL be one-hot at owner, owner SHALL hold the index, and bus_valid SHALL be 1.
REQ-018 data_q SHALL load data_in[winner] on the granting edge and data_in[owner] on every DRIVE edge; bus SHALL drive data_q in DRIVE, giving 1-cycle latency.
REQ-019 Outside DRIVE, bus SHALL be all high-Z, gnt SHALL be 0 and bus_valid SHALL be 0.
REQ-020 An edge in DRIVE sampling req[owner]=0 SHALL enter TURN for exactly TURNAROUND cycles; bus is released in the same cycle gnt falls.
REQ-021 req changes on non-owner channels during DRIVE or TURN SHALL have no effect until arbitration.
REQ-022 The owner re-requesting after release SHALL receive the lowest priority at the next arbitration.
REQ-023 If no req is high at the end of TURN, the FSM SHALL enter IDLE.
REQ-024 At most one channel SHALL be granted in any cycle, and bus SHALL never be driven in TURN, so there is no contention.

Reset
REQ-025 Assertion of rst SHALL immediately and asynchronously force IDLE, gnt=0, bus=high-Z, bus_valid=0, timeout=0, owner=0, data_q=0, last_owner=CHANNELS-1, and all counters to 0.
REQ-026 Reset mid-DRIVE SHALL release the bus without a TURN phase; the first grant after reset deassertion SHALL follow REQ-015.

Configuration
REQ-027 Macro TRISTATE_BUS_TIMEOUT_EN defined: the owner held MAX_BURST consecutive DRIVE cycles while any other req is high SHALL be forced into TURN, with timeout=1 for that first TURN cycle.
REQ-028 Macro TRISTATE_BUS_TIMEOUT_EN undefined: the owner SHALL hold indefinitely, timeout SHALL be tied 0, and no burst counter SHALL exist; the port list SHALL be unchanged.
REQ-029 With the macro defined and no competing req, the owner SHALL keep the bus past MAX_BURST, and the counter SHALL saturate.

Structure
REQ-030 Package tristate_bus_pkg SHALL hold the state enum type and the default parameter constants.
REQ-031 Round-robin selection SHALL be the combinational sub-module rr_arbiter (inputs req and last_owner; outputs winner index and any_req).

Verification (WIDTH=8, CHANNELS=4, TURNAROUND=2, MAX_BURST=4)
REQ-032 req=0001, data_in[0]=8'hA5 -> gnt=0001 one edge later, bus=A5, bus_valid=1; req=0 -> bus=ZZ for 2 cycles, then IDLE.
REQ-033 req=1111 held -> grants SHALL rotate 0,1,2,3,0 as each owner drops and re-raises req, with exactly 2 high-Z cycles between owners.
REQ-034 Owner ch2 driving 8'h3C, data_in[2] changed to 8'hC3 -> bus SHALL show C3 one cycle later.
REQ-035 rst pulsed mid-DRIVE -> bus=ZZ and gnt=0 before the next clock edge; after release with req=1000 -> ch3 granted.
REQ-036 Macro defined, ch1 owning with req=0011 held -> after 4 DRIVE cycles timeout=1 for one cycle, 2 TURN cycles, then ch0 granted; macro undefined -> ch1 holds and timeout stays 0.
REQ-037 Every scenario SHALL assert each cycle that gnt is zero or one-hot, and that bus is high-Z whenever bus_valid=0.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Shared types and default constants for the tristate bus arbiter.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_MAX_BURST  = 8;
  localparam int TURN_CNT_W     = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr.sv
// Combinational round-robin selector: the search starts one past last_owner.
module rr_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IDX_W    = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IDX_W-1:0]    last_owner_i,
  output logic [IDX_W-1:0]    winner_o,
  output logic                any_req_o
);

  logic [IDX_W-1:0] idx_s;

  assign any_req_o = |req_i;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    winner_o = '0;
    idx_s    = '0;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx_s    = IDX_W'((int'(last_owner_i) + off) % CHANNELS);
      winner_o = req_i[idx_s] ? idx_s : winner_o;
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with a turnaround gap between drivers.
// Optional burst-limit forced release is enabled by defining TRISTATE_BUS_TIMEOUT_EN.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  localparam int IDX_W     = idx_width(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            req,
  input  logic [CHANNELS-1:0][WIDTH-1:0] data_in,
  inout  tri   [WIDTH-1:0]               bus,
  output logic [CHANNELS-1:0]            gnt,
  output logic [IDX_W-1:0]               owner,
  output logic                           bus_valid,
  output logic                           timeout
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_owner_q, last_owner_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [CHANNELS-1:0]   gnt_q, gnt_d;
  logic                  valid_q, valid_d;
  logic [IDX_W-1:0]      winner_s;
  logic                  any_req_s;
  logic                  force_s;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_rr (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .winner_o     (winner_s),
    .any_req_o    (any_req_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(CHANNELS - 1);
      data_q       <= '0;
      turn_cnt_q   <= '0;
      gnt_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      turn_cnt_q   <= turn_cnt_d;
      gnt_q        <= gnt_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state logic; gnt/valid are decoded from the next state so they leave registers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    turn_cnt_d   = turn_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_DRIVE;
          owner_d = winner_s;
          data_d  = data_in[winner_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        data_d = data_in[owner_q];
        if (!req[owner_q] || force_s) begin
          state_d      = ST_TURN;
          last_owner_d = owner_q;
          turn_cnt_d   = '0;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_TURN: begin
        if (turn_cnt_q == TURN_CNT_W'(TURNAROUND - 1)) begin
          if (any_req_s) begin
            state_d = ST_DRIVE;
            owner_d = winner_s;
            data_d  = data_in[winner_s];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_DRIVE);
    gnt_d   = valid_d ? ({{(CHANNELS-1){1'b0}}, 1'b1} << owner_d) : '0;
  end

`ifdef TRISTATE_BUS_TIMEOUT_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0] burst_q, burst_d;
  logic               timeout_q, timeout_d;

  // Forced release only when the tenure is exhausted and someone else is waiting.
  assign force_s = (state_q == ST_DRIVE) && (burst_q == BURST_W'(MAX_BURST))
                   && |(req & ~gnt_q);

  // Burst counter: 1 on the granting edge, saturating while the owner keeps the bus.
  always_comb begin
    if (state_q == ST_DRIVE && state_d == ST_DRIVE) begin
      burst_d = (burst_q == BURST_W'(MAX_BURST)) ? burst_q : burst_q + BURST_W'(1);
    end else if (state_d == ST_DRIVE) begin
      burst_d = BURST_W'(1);
    end else begin
      burst_d = '0;
    end
    timeout_d = force_s && req[owner_q];
  end

  // Burst counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      burst_q   <= burst_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_s = 1'b0;
  assign timeout = 1'b0;
`endif

  assign bus       = valid_q ? data_q : {WIDTH{1'bz}};
  assign bus_valid = valid_q;
  assign gnt       = gnt_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Table-driven bench for tristate_bus_arbiter plus reset and burst-limit sequences.
module tb_tristate_bus_arbiter;

  localparam int W  = 8;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     req;
  logic [CH-1:0][W-1:0] din;
  tri   [W-1:0]      bus_w;
  logic [CH-1:0]     gnt;
  logic [1:0]        owner;
  logic              bus_valid;
  logic              timeout;
  logic              probe_en = 1'b0;

  int passed = 0;
  int total  = 0;

  // Bench-side probe: drives zeros only while checking that the DUT has released the bus.
  assign bus_w = probe_en ? 8'h00 : 8'hzz;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .WIDTH(W), .CHANNELS(CH), .TURNAROUND(2), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(din), .bus(bus_w),
    .gnt(gnt), .owner(owner), .bus_valid(bus_valid), .timeout(timeout)
  );

  typedef struct {
    logic                 rst;
    logic [CH-1:0]        req;
    logic [CH-1:0][W-1:0] din;
    logic [CH-1:0]        gnt;
    logic                 valid;
    logic [W-1:0]         bus;
    logic [1:0]           owner;
  } vec_t;

  vec_t vec [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic invariants();
    chk("gnt_onehot0", 32'((gnt & (gnt - 4'd1)) == 4'd0), 32'd1);
    chk("valid_vs_gnt", 32'(bus_valid), 32'(gnt != 4'd0));
    if (!bus_valid) begin
      probe_en = 1'b1;
      #1;
      chk("bus_hiz", 32'(bus_w), 32'h00);
      probe_en = 1'b0;
      #1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    invariants();
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [CH-1:0][W-1:0] d,
                              input logic [3:0] g, input logic v, input logic [7:0] b,
                              input logic [1:0] o);
    vec_t t;
    t.rst = r; t.req = rq; t.din = d; t.gnt = g; t.valid = v; t.bus = b; t.owner = o;
    return t;
  endfunction

  initial begin
    logic [CH-1:0][W-1:0] da, d0, d1;
    logic [3:0] g_to1, g_to2, g_to3;
    logic       t_to1;
    da = {8'h4B, 8'h3C, 8'h21, 8'hA5};
    d0 = {8'h4B, 8'h3C, 8'h21, 8'h10};
    d1 = {8'h4B, 8'hC3, 8'h21, 8'h10};

    vec[0]  = mk(1'b1, 4'b0000, da, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[1]  = mk(1'b0, 4'b0001, da, 4'b0001, 1'b1, 8'hA5, 2'd0);
    vec[2]  = mk(1'b0, 4'b0001, da, 4'b0001, 1'b1, 8'hA5, 2'd0);
    vec[3]  = mk(1'b0, 4'b0000, da, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[4]  = mk(1'b0, 4'b0000, da, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[5]  = mk(1'b0, 4'b0000, da, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[6]  = mk(1'b1, 4'b0000, d0, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[7]  = mk(1'b0, 4'b1111, d0, 4'b0001, 1'b1, 8'h10, 2'd0);
    vec[8]  = mk(1'b0, 4'b1110, d0, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[9]  = mk(1'b0, 4'b1111, d0, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[10] = mk(1'b0, 4'b1111, d0, 4'b0010, 1'b1, 8'h21, 2'd1);
    vec[11] = mk(1'b0, 4'b1101, d0, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[12] = mk(1'b0, 4'b1111, d0, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[13] = mk(1'b0, 4'b1111, d0, 4'b0100, 1'b1, 8'h3C, 2'd2);
    vec[14] = mk(1'b0, 4'b1111, d1, 4'b0100, 1'b1, 8'hC3, 2'd2);
    vec[15] = mk(1'b0, 4'b1011, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[16] = mk(1'b0, 4'b1111, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[17] = mk(1'b0, 4'b1111, d1, 4'b1000, 1'b1, 8'h4B, 2'd3);
    vec[18] = mk(1'b0, 4'b0111, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[19] = mk(1'b0, 4'b1111, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[20] = mk(1'b0, 4'b1111, d1, 4'b0001, 1'b1, 8'h10, 2'd0);
    vec[21] = mk(1'b0, 4'b0101, d1, 4'b0001, 1'b1, 8'h10, 2'd0);
    vec[22] = mk(1'b0, 4'b0011, d1, 4'b0001, 1'b1, 8'h10, 2'd0);
    vec[23] = mk(1'b0, 4'b0000, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[24] = mk(1'b0, 4'b0100, d1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vec[25] = mk(1'b0, 4'b0100, d1, 4'b0100, 1'b1, 8'hC3, 2'd2);

    rst = 1'b1; req = '0; din = '0;
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      rst = vec[i].rst; req = vec[i].req; din = vec[i].din;
      step();
      chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(vec[i].gnt));
      chk($sformatf("valid[%0d]", i), 32'(bus_valid), 32'(vec[i].valid));
      chk($sformatf("timeout[%0d]", i), 32'(timeout), 32'd0);
      if (vec[i].valid || vec[i].rst) chk($sformatf("owner[%0d]", i), 32'(owner), 32'(vec[i].owner));
      if (vec[i].valid) chk($sformatf("bus[%0d]", i), 32'(bus_w), 32'(vec[i].bus));
    end

    // Asynchronous reset while ch2 drives: released before the next clock edge.
    rst = 1'b1;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    chk("rst_async_valid", 32'(bus_valid), 32'd0);
    chk("rst_async_owner", 32'(owner), 32'd0);
    probe_en = 1'b1;
    #1;
    chk("rst_async_bus", 32'(bus_w), 32'h00);
    probe_en = 1'b0;
    step();
    rst = 1'b0; req = 4'b1000;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b1000);
    chk("post_rst_owner", 32'(owner), 32'd3);
    chk("post_rst_bus", 32'(bus_w), 32'h4B);

    // Burst limit: ch1 owns while ch0 keeps requesting.
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0; req = 4'b0010; din = d0;
    step();
    chk("to_grant_ch1", 32'(gnt), 32'b0010);
    chk("to_bus_ch1", 32'(bus_w), 32'h21);
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("to_hold[%0d]", k), 32'(gnt), 32'b0010);
      chk($sformatf("to_quiet[%0d]", k), 32'(timeout), 32'd0);
    end
`ifdef TRISTATE_BUS_TIMEOUT_EN
    g_to1 = 4'b0000; t_to1 = 1'b1; g_to2 = 4'b0000; g_to3 = 4'b0001;
`else
    g_to1 = 4'b0010; t_to1 = 1'b0; g_to2 = 4'b0010; g_to3 = 4'b0010;
`endif
    step();
    chk("to_release_gnt", 32'(gnt), 32'(g_to1));
    chk("to_pulse", 32'(timeout), 32'(t_to1));
    step();
    chk("to_turn2_gnt", 32'(gnt), 32'(g_to2));
    chk("to_pulse_end", 32'(timeout), 32'd0);
    step();
    chk("to_next_gnt", 32'(gnt), 32'(g_to3));
    chk("to_next_timeout", 32'(timeout), 32'd0);
`ifdef TRISTATE_BUS_TIMEOUT_EN
    // Uncontested owner keeps the bus past the limit; the saturated counter still fires later.
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("sat_hold[%0d]", k), 32'(gnt), 32'b0001);
      chk($sformatf("sat_quiet[%0d]", k), 32'(timeout), 32'd0);
    end
    req = 4'b0011;
    step();
    chk("sat_release_gnt", 32'(gnt), 32'd0);
    chk("sat_pulse", 32'(timeout), 32'd1);
`else
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("hold_forever[%0d]", k), 32'(gnt), 32'b0010);
      chk($sformatf("no_timeout[%0d]", k), 32'(timeout), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
